// File: rtl/mac_learn_lut_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_learn_lut_pkg
//  Description : Shared state encoding, table entry layout and MAC constants
//                for the learning MAC lookup table.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_learn_lut_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_LEARN  = 2'd2
    } state_t;

    // Entry layout, LSB first: mac, oq bitmap, protect bit, valid bit
    localparam int MAC_W   = 48;
    localparam int MAC_LSB = 0;
    localparam int OQ_LSB  = MAC_LSB + MAC_W;

    // Protect/valid positions depend on the bitmap width of the instance
    function automatic int prot_bit(input int oq_w);
        return OQ_LSB + oq_w;
    endfunction

    function automatic int valid_bit(input int oq_w);
        return OQ_LSB + oq_w + 1;
    endfunction

    // Positions for the default 8-queue bitmap
    localparam int PROT_BIT  = OQ_LSB + 8;
    localparam int VALID_BIT = OQ_LSB + 9;

    localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/mac_lut_match.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lut_match
//  Description : Parallel compare of a MAC key against every table entry with
//                lowest-index priority, plus lowest free entry finder.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_lut_match #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic [47:0]            key,
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH-1:0][47:0] macs,
    output logic                   match,
    output logic [AW-1:0]          match_addr,
    output logic [AW-1:0]          first_free,
    output logic                   first_free_valid
);

    // Scan from the top down so the lowest index is the last to win
    always_comb begin
        match            = 1'b0;
        match_addr       = '0;
        first_free       = '0;
        first_free_valid = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (macs[i] == key)) begin
                match      = 1'b1;
                match_addr = AW'(i);
            end
            if (!valid[i]) begin
                first_free_valid = 1'b1;
                first_free       = AW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_learn_lut.sv
`default_nettype none
// ============================================================================
//  Module      : mac_learn_lut
//  Description : Learning MAC lookup table. Resolves destination MAC to an
//                output-queue bitmap, then learns/refreshes the source MAC.
//                Register read/write access to every entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_learn_lut
    import mac_learn_lut_pkg::*;
#(
    parameter int                           NUM_OUTPUT_QUEUES         = 8,
    parameter int                           NUM_IQ_BITS               = 3,
    parameter int                           LUT_DEPTH_BITS            = 4,
    parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_MISS_OUTPUT_PORTS = 8'h55
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [47:0]                  dst_mac,
    input  logic [47:0]                  src_mac,
    input  logic [NUM_IQ_BITS-1:0]       src_port,
    input  logic                         lookup_req,
    output logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    output logic                         lookup_ack,
    output logic                         lut_hit,
    output logic                         lut_miss,
    output logic                         lut_learn,
    input  logic [LUT_DEPTH_BITS-1:0]    rd_addr,
    input  logic                         rd_req,
    output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
    output logic                         rd_wr_protect,
    output logic [47:0]                  rd_mac,
    output logic                         rd_ack,
    input  logic [LUT_DEPTH_BITS-1:0]    wr_addr,
    input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
    input  logic                         wr_protect,
    input  logic [47:0]                  wr_mac,
    input  logic                         wr_req,
    output logic                         wr_ack
);

    localparam int c_LUT_DEPTH = 2 ** LUT_DEPTH_BITS;
    localparam int c_PROT_BIT  = prot_bit(NUM_OUTPUT_QUEUES);
    localparam int c_VALID_BIT = valid_bit(NUM_OUTPUT_QUEUES);
    localparam int c_ENTRY_W   = c_VALID_BIT + 1;

    state_t                         r_state, w_state_nxt;
    logic [c_ENTRY_W-1:0]           r_lut [c_LUT_DEPTH];
    logic [47:0]                    r_dst, r_src;
    logic [NUM_OUTPUT_QUEUES-1:0]   r_src_dec;
    logic [LUT_DEPTH_BITS-1:0]      r_rp;
    logic [NUM_OUTPUT_QUEUES-1:0]   r_dst_ports, r_rd_oq;
    logic                           r_lookup_ack, r_hit, r_miss;
    logic                           r_rd_wp, r_rd_ack, r_wr_ack;
    logic [47:0]                    r_rd_mac;

    logic [c_LUT_DEPTH-1:0]         w_valid;
    logic [c_LUT_DEPTH-1:0][47:0]   w_macs;
    logic [47:0]                    w_key;
    logic                           w_match, w_ff_valid;
    logic [LUT_DEPTH_BITS-1:0]      w_match_addr, w_first_free, w_victim;
    logic                           w_wr_go, w_lk_go, w_rd_go;
    logic                           w_lk_hit;
    logic [NUM_OUTPUT_QUEUES-1:0]   w_lk_ports;
    logic                           w_learn_we, w_rp_inc;
    logic [LUT_DEPTH_BITS-1:0]      w_learn_addr;
    logic [c_ENTRY_W-1:0]           w_learn_entry;

    generate
        for (genvar gi = 0; gi < c_LUT_DEPTH; gi++) begin : g_unpack
            assign w_valid[gi] = r_lut[gi][c_VALID_BIT];
            assign w_macs[gi]  = r_lut[gi][MAC_LSB +: MAC_W];
        end
    endgenerate

    // One comparator shared between destination lookup and source learning
    assign w_key = (r_state == ST_LEARN) ? r_src : r_dst;

    mac_lut_match #(
        .DEPTH (c_LUT_DEPTH),
        .AW    (LUT_DEPTH_BITS)
    ) u_match (
        .key              (w_key),
        .valid            (w_valid),
        .macs             (w_macs),
        .match            (w_match),
        .match_addr       (w_match_addr),
        .first_free       (w_first_free),
        .first_free_valid (w_ff_valid)
    );

    // Request arbitration: write beats lookup; reads only yield to writes
    assign w_wr_go = (r_state == ST_IDLE) && wr_req && !r_wr_ack;
    assign w_lk_go = (r_state == ST_IDLE) && !w_wr_go && lookup_req && !r_lookup_ack;
    assign w_rd_go = (r_state == ST_IDLE) && !wr_req && rd_req && !r_rd_ack;

    // Destination resolution; broadcast always floods
    assign w_lk_hit   = w_match && (r_dst != BCAST_MAC);
    assign w_lk_ports = (w_lk_hit ? r_lut[w_match_addr][OQ_LSB +: NUM_OUTPUT_QUEUES]
                                  : DEFAULT_MISS_OUTPUT_PORTS) & ~r_src_dec;

    // Next-state and learn decision
    always_comb begin
        w_state_nxt   = ST_IDLE;
        w_learn_we    = 1'b0;
        w_rp_inc      = 1'b0;
        w_victim      = w_ff_valid ? w_first_free : r_rp;
        w_learn_addr  = w_match_addr;
        w_learn_entry = r_lut[w_match_addr];
        case (r_state)
            ST_IDLE:   w_state_nxt = w_lk_go ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP: w_state_nxt = ST_LEARN;
            ST_LEARN: begin
                w_state_nxt = ST_IDLE;
                if ((r_src != BCAST_MAC) && (r_src != '0)) begin
                    if (w_match) begin
                        if (!r_lut[w_match_addr][c_PROT_BIT] &&
                            (r_lut[w_match_addr][OQ_LSB +: NUM_OUTPUT_QUEUES] != r_src_dec)) begin
                            w_learn_we = 1'b1;
                            w_learn_entry[OQ_LSB +: NUM_OUTPUT_QUEUES] = r_src_dec;
                        end
                    end else begin
                        w_learn_addr  = w_victim;
                        w_learn_entry = {1'b1, 1'b0, r_src_dec, r_src};
                        w_learn_we    = !r_lut[w_victim][c_PROT_BIT];
                        w_rp_inc      = !w_ff_valid;
                    end
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Table storage: register writes in IDLE, learn writes in LEARN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_LUT_DEPTH; i++) r_lut[i] <= '0;
        end else if (w_wr_go) begin
            r_lut[wr_addr] <= {(wr_mac != '0), wr_protect, wr_oq, wr_mac};
        end else if (w_learn_we) begin
            r_lut[w_learn_addr] <= w_learn_entry;
        end
    end

    // Lookup latch, replacement pointer and lookup handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dst        <= '0;
            r_src        <= '0;
            r_src_dec    <= '0;
            r_rp         <= '0;
            r_dst_ports  <= '0;
            r_lookup_ack <= 1'b0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
        end else begin
            if (w_lk_go) begin
                r_dst     <= dst_mac;
                r_src     <= src_mac;
                r_src_dec <= NUM_OUTPUT_QUEUES'(1) << src_port;
            end
            if (w_rp_inc) r_rp <= r_rp + 1'b1;
            r_hit  <= (r_state == ST_LOOKUP) && w_lk_hit;
            r_miss <= (r_state == ST_LOOKUP) && !w_lk_hit;
            if (r_state == ST_LOOKUP) begin
                r_dst_ports  <= w_lk_ports;
                r_lookup_ack <= 1'b1;
            end else if (!lookup_req) begin
                r_lookup_ack <= 1'b0;
            end
        end
    end

    // Register read/write acknowledges and held read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_oq  <= '0;
            r_rd_wp  <= 1'b0;
            r_rd_mac <= '0;
            r_rd_ack <= 1'b0;
            r_wr_ack <= 1'b0;
        end else begin
            r_rd_ack <= w_rd_go;
            r_wr_ack <= w_wr_go;
            if (w_rd_go) begin
                r_rd_oq  <= r_lut[rd_addr][OQ_LSB +: NUM_OUTPUT_QUEUES];
                r_rd_wp  <= r_lut[rd_addr][c_PROT_BIT];
                r_rd_mac <= r_lut[rd_addr][MAC_LSB +: MAC_W];
            end
        end
    end

    assign dst_ports     = r_dst_ports;
    assign lookup_ack    = r_lookup_ack;
    assign lut_hit       = r_hit;
    assign lut_miss      = r_miss;
    assign lut_learn     = w_learn_we;
    assign rd_oq         = r_rd_oq;
    assign rd_wr_protect = r_rd_wp;
    assign rd_mac        = r_rd_mac;
    assign rd_ack        = r_rd_ack;
    assign wr_ack        = r_wr_ack;

endmodule
`default_nettype wire

// File: tb/tb_mac_learn_lut.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_learn_lut
//  Description : Directed self-checking bench for mac_learn_lut.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_learn_lut;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] dst_mac, src_mac, rd_mac, wr_mac;
    logic [2:0]  src_port;
    logic        lookup_req, lookup_ack, lut_hit, lut_miss, lut_learn;
    logic [7:0]  dst_ports, rd_oq, wr_oq;
    logic [3:0]  rd_addr, wr_addr;
    logic        rd_req, rd_wr_protect, rd_ack, wr_protect, wr_req, wr_ack;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [47:0] M1 = 48'h0000_0000_0001;
    localparam logic [47:0] M2 = 48'h0000_0000_0002;
    localparam logic [47:0] M5 = 48'h0000_0000_0005;
    localparam logic [47:0] MA = 48'h0000_0000_00AA;
    localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;

    mac_learn_lut dut (
        .clk(clk), .reset(reset),
        .dst_mac(dst_mac), .src_mac(src_mac), .src_port(src_port),
        .lookup_req(lookup_req), .dst_ports(dst_ports), .lookup_ack(lookup_ack),
        .lut_hit(lut_hit), .lut_miss(lut_miss), .lut_learn(lut_learn),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_oq(rd_oq),
        .rd_wr_protect(rd_wr_protect), .rd_mac(rd_mac), .rd_ack(rd_ack),
        .wr_addr(wr_addr), .wr_oq(wr_oq), .wr_protect(wr_protect),
        .wr_mac(wr_mac), .wr_req(wr_req), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    // Full lookup handshake; results captured in cycle 2 and cycle 3
    task automatic do_lookup(input logic [47:0] dst, input logic [47:0] src, input logic [2:0] port,
                             output logic [7:0] ports, output logic hit, output logic miss,
                             output logic learn, output logic ack2, output logic ack3);
        dst_mac = dst; src_mac = src; src_port = port; lookup_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ports = dst_ports; hit = lut_hit; miss = lut_miss; learn = lut_learn; ack2 = lookup_ack;
        lookup_req = 1'b0;
        @(negedge clk);
        ack3 = lookup_ack;
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [7:0] oq, output logic wp,
                           output logic [47:0] mac, output logic ack);
        rd_addr = addr; rd_req = 1'b1;
        @(negedge clk);
        oq = rd_oq; wp = rd_wr_protect; mac = rd_mac; ack = rd_ack;
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [47:0] mac, input logic [7:0] oq,
                            input logic prot, output logic ack);
        wr_addr = addr; wr_mac = mac; wr_oq = oq; wr_protect = prot; wr_req = 1'b1;
        @(negedge clk);
        ack = wr_ack;
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] oq; logic wp, ack; logic [47:0] mac;
        reset = 1'b1;
        dst_mac = '0; src_mac = '0; src_port = '0; lookup_req = 1'b0;
        rd_addr = '0; rd_req = 1'b0; wr_addr = '0; wr_oq = '0; wr_protect = 1'b0;
        wr_mac = '0; wr_req = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({dst_ports, lookup_ack, lut_hit, lut_miss, lut_learn} !== 12'h000) begin
            n_fail++; $display("FAIL reset_lookup_outs: got %h expected 000", {dst_ports, lookup_ack, lut_hit, lut_miss, lut_learn});
        end
        n_checks++;
        if ({rd_oq, rd_wr_protect, rd_mac, rd_ack, wr_ack} !== 59'h0) begin
            n_fail++; $display("FAIL reset_reg_outs: got %h expected 0", {rd_oq, rd_wr_protect, rd_mac, rd_ack, wr_ack});
        end
        reset = 1'b0;
        @(negedge clk);
        do_read(4'd0, oq, wp, mac, ack);
        n_checks++;
        if ({ack, oq, wp, mac} !== {1'b1, 8'h00, 1'b0, 48'h0}) begin
            n_fail++; $display("FAIL reset_entry0: got %h expected %h", {ack, oq, wp, mac}, {1'b1, 57'h0});
        end
    endtask

    task automatic test_miss_learn();
        logic [7:0] p, oq; logic h, m, l, a2, a3, wp, ack; logic [47:0] mac;
        do_lookup(48'h0011_2233_4455, M1, 3'd2, p, h, m, l, a2, a3);
        n_checks++;
        if ({a2, p, h, m, l} !== {1'b1, 8'h51, 1'b0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL miss_learn_c2: got ack/ports/hit/miss/learn=%h expected %h", {a2, p, h, m, l}, {1'b1, 8'h51, 3'b011});
        end
        n_checks++;
        if (a3 !== 1'b0) begin n_fail++; $display("FAIL miss_ack_drop: got %b expected 0", a3); end
        do_read(4'd0, oq, wp, mac, ack);
        n_checks++;
        if ({oq, wp, mac} !== {8'h04, 1'b0, M1}) begin
            n_fail++; $display("FAIL miss_entry0: got %h expected %h", {oq, wp, mac}, {8'h04, 1'b0, M1});
        end
    endtask

    task automatic test_hit_learn();
        logic [7:0] p, oq; logic h, m, l, a2, a3, wp, ack; logic [47:0] mac;
        do_lookup(M1, M2, 3'd0, p, h, m, l, a2, a3);
        n_checks++;
        if ({a2, p, h, m, l} !== {1'b1, 8'h04, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL hit_c2: got %h expected %h", {a2, p, h, m, l}, {1'b1, 8'h04, 3'b101});
        end
        do_read(4'd1, oq, wp, mac, ack);
        n_checks++;
        if ({oq, wp, mac} !== {8'h01, 1'b0, M2}) begin
            n_fail++; $display("FAIL hit_entry1: got %h expected %h", {oq, wp, mac}, {8'h01, 1'b0, M2});
        end
    endtask

    task automatic test_station_move();
        logic [7:0] p, oq; logic h, m, l, a2, a3, wp, ack; logic [47:0] mac;
        do_lookup(48'h99, M1, 3'd4, p, h, m, l, a2, a3);
        n_checks++;
        if ({p, m, l} !== {8'h45, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL move_c2: got %h expected %h", {p, m, l}, {8'h45, 2'b11});
        end
        do_read(4'd0, oq, wp, mac, ack);
        n_checks++;
        if ({oq, mac} !== {8'h10, M1}) begin
            n_fail++; $display("FAIL move_entry0: got %h expected %h", {oq, mac}, {8'h10, M1});
        end
        do_lookup(48'h99, M1, 3'd4, p, h, m, l, a2, a3);
        n_checks++;
        if ({p, l} !== {8'h45, 1'b0}) begin
            n_fail++; $display("FAIL move_repeat: got %h expected %h", {p, l}, {8'h45, 1'b0});
        end
    endtask

    task automatic test_protect();
        logic [7:0] p, oq; logic h, m, l, a2, a3, wp, ack; logic [47:0] mac;
        do_write(4'd3, MA, 8'h02, 1'b1, ack);
        n_checks++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL prot_wr_ack: got %b expected 1", ack); end
        do_lookup(M1, MA, 3'd6, p, h, m, l, a2, a3);
        n_checks++;
        if ({p, h, l} !== {8'h10, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL prot_lookup: got %h expected %h", {p, h, l}, {8'h10, 2'b10});
        end
        do_read(4'd3, oq, wp, mac, ack);
        n_checks++;
        if ({ack, oq, wp, mac} !== {1'b1, 8'h02, 1'b1, MA}) begin
            n_fail++; $display("FAIL prot_entry3: got %h expected %h", {ack, oq, wp, mac}, {1'b1, 8'h02, 1'b1, MA});
        end
    endtask

    task automatic test_broadcast();
        logic [7:0] p; logic h, m, l, a2, a3, ack;
        do_write(4'd5, BC, 8'hFF, 1'b0, ack);
        do_lookup(BC, M5, 3'd0, p, h, m, l, a2, a3);
        n_checks++;
        if ({p, h, m, l} !== {8'h54, 1'b0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL bcast_dst: got %h expected %h", {p, h, m, l}, {8'h54, 3'b011});
        end
        do_lookup(M5, BC, 3'd3, p, h, m, l, a2, a3);
        n_checks++;
        if ({p, h, l} !== {8'h01, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL bcast_src: got %h expected %h", {p, h, l}, {8'h01, 2'b10});
        end
        do_lookup(M5, 48'h0, 3'd1, p, h, m, l, a2, a3);
        n_checks++;
        if ({p, h, l} !== {8'h01, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL zero_src: got %h expected %h", {p, h, l}, {8'h01, 2'b10});
        end
    endtask

    task automatic test_priority();
        wr_addr = 4'd7; wr_mac = 48'h77; wr_oq = 8'h08; wr_protect = 1'b0; wr_req = 1'b1;
        dst_mac = 48'h77; src_mac = M2; src_port = 3'd1; lookup_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({wr_ack, lookup_ack} !== 2'b10) begin
            n_fail++; $display("FAIL prio_c1: got wr_ack/lookup_ack=%b expected 10", {wr_ack, lookup_ack});
        end
        wr_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lookup_ack !== 1'b0) begin n_fail++; $display("FAIL prio_c2_ack: got %b expected 0", lookup_ack); end
        @(negedge clk);
        n_checks++;
        if ({lookup_ack, dst_ports, lut_hit} !== {1'b1, 8'h08, 1'b1}) begin
            n_fail++; $display("FAIL prio_c3: got %h expected %h", {lookup_ack, dst_ports, lut_hit}, {1'b1, 8'h08, 1'b1});
        end
        lookup_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_lookup();
        logic [7:0] oq; logic wp, ack; logic [47:0] mac;
        logic [3:0] addrs [6];
        addrs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7};
        do_read(4'd3, oq, wp, mac, ack);
        dst_mac = M1; src_mac = 48'h0A; src_port = 3'd2; lookup_req = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({lookup_ack, rd_oq, rd_wr_protect, rd_mac} !== 58'h0) begin
            n_fail++; $display("FAIL rst_mid_immediate: got %h expected 0", {lookup_ack, rd_oq, rd_wr_protect, rd_mac});
        end
        @(negedge clk);
        n_checks++;
        if ({lookup_ack, dst_ports, lut_hit, lut_miss, lut_learn} !== 12'h0) begin
            n_fail++; $display("FAIL rst_mid_held: got %h expected 0", {lookup_ack, dst_ports, lut_hit, lut_miss, lut_learn});
        end
        lookup_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        foreach (addrs[k]) begin
            do_read(addrs[k], oq, wp, mac, ack);
            n_checks++;
            if ({ack, oq, wp, mac} !== {1'b1, 57'h0}) begin
                n_fail++; $display("FAIL rst_mid_clear[%0d]: got %h expected %h", addrs[k], {ack, oq, wp, mac}, {1'b1, 57'h0});
            end
        end
    endtask

    task automatic test_replacement();
        logic [7:0] p, oq; logic h, m, l, a2, a3, wp, ack; logic [47:0] mac;
        for (int i = 0; i < 16; i++) begin
            do_lookup(48'hEEE, 48'h100 + 48'(i), 3'(i), p, h, m, l, a2, a3);
            n_checks++;
            if (l !== 1'b1) begin n_fail++; $display("FAIL fill_learn[%0d]: got %b expected 1", i, l); end
        end
        do_lookup(48'hEEE, 48'h200, 3'd5, p, h, m, l, a2, a3);
        n_checks++;
        if (l !== 1'b1) begin n_fail++; $display("FAIL repl_n1_learn: got %b expected 1", l); end
        do_lookup(48'hEEE, 48'h201, 3'd6, p, h, m, l, a2, a3);
        n_checks++;
        if (l !== 1'b1) begin n_fail++; $display("FAIL repl_n2_learn: got %b expected 1", l); end
        do_read(4'd0, oq, wp, mac, ack);
        n_checks++;
        if ({oq, mac} !== {8'h20, 48'h200}) begin
            n_fail++; $display("FAIL repl_entry0: got %h expected %h", {oq, mac}, {8'h20, 48'h200});
        end
        do_read(4'd1, oq, wp, mac, ack);
        n_checks++;
        if ({oq, mac} !== {8'h40, 48'h201}) begin
            n_fail++; $display("FAIL repl_entry1: got %h expected %h", {oq, mac}, {8'h40, 48'h201});
        end
        do_read(4'd2, oq, wp, mac, ack);
        n_checks++;
        if ({oq, mac} !== {8'h04, 48'h102}) begin
            n_fail++; $display("FAIL repl_entry2: got %h expected %h", {oq, mac}, {8'h04, 48'h102});
        end
    endtask

    task automatic test_replacement_protect();
        logic [7:0] p, oq; logic h, m, l, a2, a3, wp, ack; logic [47:0] mac;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_write(4'd0, 48'h300, 8'h01, 1'b1, ack);
        for (int i = 1; i < 16; i++) begin
            do_lookup(48'hEEE, 48'h400 + 48'(i), 3'(i), p, h, m, l, a2, a3);
            n_checks++;
            if (l !== 1'b1) begin n_fail++; $display("FAIL pfill_learn[%0d]: got %b expected 1", i, l); end
        end
        do_lookup(48'hEEE, 48'h500, 3'd2, p, h, m, l, a2, a3);
        n_checks++;
        if (l !== 1'b0) begin n_fail++; $display("FAIL prepl_drop: got %b expected 0", l); end
        do_lookup(48'hEEE, 48'h501, 3'd3, p, h, m, l, a2, a3);
        n_checks++;
        if (l !== 1'b1) begin n_fail++; $display("FAIL prepl_n2_learn: got %b expected 1", l); end
        do_read(4'd0, oq, wp, mac, ack);
        n_checks++;
        if ({oq, wp, mac} !== {8'h01, 1'b1, 48'h300}) begin
            n_fail++; $display("FAIL prepl_entry0: got %h expected %h", {oq, wp, mac}, {8'h01, 1'b1, 48'h300});
        end
        do_read(4'd1, oq, wp, mac, ack);
        n_checks++;
        if ({oq, wp, mac} !== {8'h08, 1'b0, 48'h501}) begin
            n_fail++; $display("FAIL prepl_entry1: got %h expected %h", {oq, wp, mac}, {8'h08, 1'b0, 48'h501});
        end
    endtask

    initial begin
        test_reset();
        test_miss_learn();
        test_hit_learn();
        test_station_move();
        test_protect();
        test_broadcast();
        test_priority();
        test_reset_mid_lookup();
        test_replacement();
        test_replacement_protect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_learn_lut.md
# mac_learn_lut

Learning MAC lookup table for the output-port-lookup stage of the learning switch. It replaces the external CAM-based lookup with an in-fabric register CAM of parametrised depth. It resolves the destination MAC to an output-queue bitmap, then learns or refreshes the source MAC → source-port mapping. It also exposes direct register read/write access to every entry.

## Interface
- NUM_OUTPUT_QUEUES, 8, width of the output-queue bitmap
- NUM_IQ_BITS, 3, width of the source-port number
- LUT_DEPTH_BITS, 4, log2 of the number of entries (LUT_DEPTH = 2**LUT_DEPTH_BITS)
- DEFAULT_MISS_OUTPUT_PORTS, 8'h55, flood bitmap used on a miss or broadcast

Ports:
- clk  in  1  the block's one clock
- reset  in  1  asynchronous, active-high
- dst_mac  in  48  destination MAC, sampled when a lookup is accepted
- src_mac  in  48  source MAC, sampled when a lookup is accepted
- src_port  in  NUM_IQ_BITS  ingress port, sampled when a lookup is accepted
- lookup_req  in  1  level request, 4-phase with lookup_ack
- dst_ports  out  NUM_OUTPUT_QUEUES  result bitmap, valid while lookup_ack=1
- lookup_ack  out  1  set when the result is ready; held until lookup_req falls
- lut_hit / lut_miss  out  1 each  one-cycle pulse per completed lookup
- lut_learn  out  1  one-cycle pulse when an entry is written by learning
- rd_addr  in  LUT_DEPTH_BITS  entry to read
- rd_req  in  1  read request
- rd_oq  out  NUM_OUTPUT_QUEUES  stored bitmap of the entry
- rd_wr_protect  out  1  protect bit of the entry
- rd_mac  out  48  MAC of the entry
- rd_ack  out  1  one-cycle pulse; rd_oq, rd_wr_protect and rd_mac hold until the next read
- wr_addr, wr_oq, wr_protect, wr_mac  in  entry write data (LUT_DEPTH_BITS, NUM_OUTPUT_QUEUES, 1, 48 bits)
- wr_req  in  1  write request
- wr_ack  out  1  one-cycle pulse

## Operation
- Entry format: {valid, wr_protect, oq[NUM_OUTPUT_QUEUES], mac[48]}. Reset clears every entry.
- States: IDLE, LOOKUP, LEARN. Reset state is IDLE.
- IDLE:
  - Serve the request with the highest priority: wr_req, then lookup_req, then rd_req.
  - A request is accepted only while its own ack is low.
  - Accepting a lookup latches dst_mac, src_mac and decoded src_port (src_dec), then moves to LOOKUP.
  - rd_req is served whenever wr_req is low, including the cycle in which a lookup is accepted.
- LOOKUP:
  - Compare dst against all valid entries. On multiple matches, the lowest index wins.
  - dst_mac = 48'hFFFF_FFFF_FFFF forces a miss.
  - Hit: dst_ports = oq & ~src_dec.
  - Miss: dst_ports = DEFAULT_MISS_OUTPUT_PORTS & ~src_dec.
  - Go to LEARN.
- LEARN: compare the latched src against all valid entries.
  - Match, not protected, oq != src_dec: rewrite oq = src_dec and pulse lut_learn.
  - Match, protected: no write.
  - No match: victim = lowest-index invalid entry; if there is none, victim = the replacement pointer rp.
    - If the victim is not protected: write {1,0,src_dec,src_mac} and pulse lut_learn.
    - If no invalid entry was found, rp increments modulo LUT_DEPTH, whether or not the write happened.
  - Source MAC that is broadcast or zero: never learned.
  - Return to IDLE.
- Register write:
  - Writes the entry with valid = (wr_mac != 0).
  - wr_mac = 0 deletes the entry.
- Reset mid-lookup: the state machine returns to IDLE, lookup_ack drops, and the table is cleared.

## Timing
- Reset values: every output is 0; rp = 0.
- Lookup, with cycle 0 = lookup_req sampled in IDLE:
  - Cycle 1: LOOKUP.
  - Cycle 2: lookup_ack=1, dst_ports valid, lut_hit or lut_miss pulses. State is LEARN.
  - End of cycle 2: the learn write lands. Cycle 3: IDLE.
  - A lookup in cycle 3 or later sees the learned entry.
- lookup_ack falls on the cycle after lookup_req is sampled low. A new lookup needs lookup_req low for at least one cycle.
- rd_ack and wr_ack are asserted the cycle after acceptance. A write is visible to a lookup accepted in the same cycle as the wr_ack.
- A register write that is pending while the state is LOOKUP or LEARN waits for IDLE (worst case 2 cycles).
- A read in the same IDLE cycle as a learn landing returns the pre-write data.

## Structure
- Package mac_learn_lut_pkg holds:
  - the state encoding constants;
  - the entry field offsets/widths (VALID_BIT, PROT_BIT, OQ_LSB, MAC_LSB);
  - BCAST_MAC = 48'hFFFF_FFFF_FFFF.
- Sub-module mac_lut_match: combinational parallel compare of a 48-bit key against all entries plus a priority encoder. Outputs match, match_addr, first_free and first_free_valid.
- There is a single mac_lut_match instance. Its key is the latched dst in LOOKUP and the latched src in LEARN, so compare logic is not duplicated.

## Test plan
- Empty table; lookup with dst=00:11:22:33:44:55, src=..:01, src_port=2 → cycle 2: dst_ports=8'h51, lut_miss=1. Entry 0 = {1,0,8'h04,..:01}, lut_learn=1.
- Then a lookup with dst=..:01, src_port=0 → dst_ports=8'h04, lut_hit=1. Learn the source into entry 1.
- Station moves: lookup with src=..:01, src_port=4 → entry 0 oq becomes 8'h10 and lut_learn pulses. Repeating the same lookup → no lut_learn.
- Register write addr 3, mac=..:AA, oq=8'h02, protect=1 → wr_ack at +1. Lookup with src=..:AA, src_port=6 → no write. Read addr 3 → rd_oq=8'h02, rd_wr_protect=1, rd_mac=..:AA.
- Replacement: fill all 16 entries by learning, then learn 2 new MACs → they land in entries 0 and 1 (rp=2). If entry 0 is protected, the first new MAC is dropped and rp still advances.
- Broadcast dst from src_port=0 → dst_ports=8'h54 (miss). wr_req and lookup_req high together in IDLE → write served first, lookup_ack at +3.
- Reset asserted in LOOKUP → lookup_ack and all outputs low immediately; all reads return 0.
